dmem_arbiter: RTL

- Shares the single-port 32-word data memory between two requesters: the pipeline MEM stage (core) and a DMA/debug loader (dma).
- Core has default priority. A wait counter forces a DMA slot after STARVE_LIMIT stalled cycles. Once granted, the DMA holds the port for a burst of up to BURST_MAX words.
- Sits between the pipeline/loader and data_mem. It drives data_mem's r_enable, w_enable, address and wr_data, and routes its combinational read data back to the winner.

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM stage
// (core, default priority) and a DMA/debug loader with starvation override and bounded bursts.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_ready_o,
  output logic        core_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic        dma_last_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ready_o,
  output logic        mem_r_enable_o,
  output logic        mem_w_enable_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_wr_data_o,
  input  logic [31:0] mem_re_data_i
);

  typedef enum logic [0:0] {
    CORE_PRI  = 1'b0,
    DMA_BURST = 1'b1
  } state_e;

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
  localparam logic [8:0] BURST_MAX_C  = 9'(BURST_MAX);
  localparam logic       MULTI_BURST_C = (BURST_MAX > 32'd1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        core_gnt_s, dma_gnt_s;
  logic [8:0]  burst_inc_s;

  assign burst_inc_s = {1'b0, burst_cnt_q} + 9'd1;

  // Grant decision; gated by rst_n so nothing reaches memory while reset is held
  always_comb begin
    core_gnt_s = 1'b0;
    dma_gnt_s  = 1'b0;
    if (rst_n) begin
      case (state_q)
        CORE_PRI: begin
          if (dma_req_i && (wait_cnt_q == STARVE_LIM_C)) begin
            dma_gnt_s = 1'b1;
          end else if (core_req_i) begin
            core_gnt_s = 1'b1;
          end else if (dma_req_i) begin
            dma_gnt_s = 1'b1;
          end else begin
            dma_gnt_s = 1'b0;
          end
        end
        DMA_BURST: dma_gnt_s = dma_req_i;
        default: begin
          core_gnt_s = 1'b0;
          dma_gnt_s  = 1'b0;
        end
      endcase
    end else begin
      core_gnt_s = 1'b0;
      dma_gnt_s  = 1'b0;
    end
  end

  // Memory port mux and read-data routing back to the winner
  always_comb begin
    mem_r_enable_o = 1'b0;
    mem_w_enable_o = 1'b0;
    mem_address_o  = 32'd0;
    mem_wr_data_o  = 32'd0;
    core_rdata_o   = 32'd0;
    dma_rdata_o    = 32'd0;
    if (core_gnt_s) begin
      mem_r_enable_o = ~core_we_i;
      mem_w_enable_o = core_we_i;
      mem_address_o  = core_addr_i;
      mem_wr_data_o  = core_wdata_i;
      core_rdata_o   = core_we_i ? 32'd0 : mem_re_data_i;
    end else if (dma_gnt_s) begin
      mem_r_enable_o = ~dma_we_i;
      mem_w_enable_o = dma_we_i;
      mem_address_o  = dma_addr_i;
      mem_wr_data_o  = dma_wdata_i;
      dma_rdata_o    = dma_we_i ? 32'd0 : mem_re_data_i;
    end else begin
      mem_r_enable_o = 1'b0;
    end
  end

  assign core_ready_o = core_gnt_s;
  assign dma_ready_o  = dma_gnt_s;
  assign core_stall_o = core_req_i & ~core_gnt_s;

  // Next-state, burst length and starvation counter
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      CORE_PRI: begin
        burst_cnt_d = 8'd0;
        if (dma_gnt_s && !dma_last_i && MULTI_BURST_C) begin
          state_d     = DMA_BURST;
          burst_cnt_d = 8'd1;
        end else begin
          state_d = CORE_PRI;
        end
      end
      DMA_BURST: begin
        if (dma_gnt_s) begin
          if (dma_last_i || (burst_inc_s == BURST_MAX_C)) begin
            state_d     = CORE_PRI;
            burst_cnt_d = 8'd0;
          end else begin
            state_d     = DMA_BURST;
            burst_cnt_d = burst_inc_s[7:0];
          end
        end else begin
          state_d     = CORE_PRI;
          burst_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = CORE_PRI;
        burst_cnt_d = 8'd0;
      end
    endcase

    if (dma_gnt_s || !dma_req_i) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < STARVE_LIM_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CORE_PRI;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule
